// File: rtl/fpu_pkg.sv
// Shared single-precision-style format constants, special-value classes and
// the pipeline stage records used by the floating-point multiplier.
package fpu_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_TAG_W = 4;
  localparam int FP_SIG_W = FP_MAN_W + 1;
  localparam int FP_LO_W  = FP_SIG_W / 2;
  localparam int FP_HI_W  = FP_SIG_W - FP_LO_W;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Exponents are two's complement, two bits wider than the field, so that
  // underflow and overflow remain visible until the final packing.
  typedef struct packed {
    logic                          sign;
    logic [FP_EXP_W+1:0]           exp;
    cls_e                          cls;
    logic [FP_SIG_W+FP_HI_W-1:0]   pp_hi;
    logic [FP_SIG_W+FP_LO_W-1:0]   pp_lo;
    logic                          rnd_mode;
    logic [FP_TAG_W-1:0]           tag;
  } s1_t;

  typedef struct packed {
    logic                          sign;
    logic [FP_EXP_W+1:0]           exp;
    cls_e                          cls;
    logic [FP_SIG_W-1:0]           sig;
    logic                          guard;
    logic                          round;
    logic                          sticky;
    logic                          rnd_mode;
    logic [FP_TAG_W-1:0]           tag;
  } s2_t;

endpackage

// File: rtl/fmul_round.sv
// Rounds a normalised significand using guard/round/sticky bits and
// renormalises when the increment carries out of the significand.
module fmul_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]   sig,
  input  logic             guard,
  input  logic             round,
  input  logic             sticky,
  input  logic             rnd_mode,
  input  logic [EXP_W+1:0] exp_in,
  output logic [MAN_W-1:0] man,
  output logic [EXP_W+1:0] exp_out
);

  logic             inc;
  logic [MAN_W+1:0] sum;

  assign inc = !rnd_mode && guard && (round || sticky || sig[0]);
  assign sum = {1'b0, sig} + (MAN_W+2)'(inc);

  // A carry out can only come from an all-ones significand, so the result is exactly 2.0.
  assign man     = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign exp_out = exp_in + (EXP_W+2)'(sum[MAN_W+1]);

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshakes,
// flush-to-zero inputs, selectable rounding and a sideband tag.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = FP_TAG_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x1,
  input  logic [EXP_W+MAN_W:0] x2,
  input  logic                 rnd_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [TAG_W-1:0]     out_tag,
  output logic [2:0]           flags
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int LO_W   = SIG_W / 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W+1:0] BIAS_E   = (EXP_W+2)'(bias(EXP_W));

  function automatic cls_e classify(input logic [EXP_W+MAN_W:0] x);
    if (x[MAN_W +: EXP_W] == '0)       return ZERO;
    if (x[MAN_W +: EXP_W] == EXP_ONES) return (x[MAN_W-1:0] == '0) ? INF : NAN;
    return NORM;
  endfunction

  s1_t                 s1_d, s1_q;
  s2_t                 s2_d, s2_q;
  logic                v1, v2, v3;
  logic                en1, en2, en3;
  cls_e                c1, c2;
  logic [SIG_W-1:0]    a_sig, b_sig;
  logic [PROD_W-1:0]   prod, norm;
  logic [MAN_W-1:0]    man_r;
  logic [EXP_W+1:0]    exp_r;
  logic [EXP_W+MAN_W:0] y_d;
  logic [2:0]          flags_d;

  // A stage may load when it is empty or its content moves on this cycle.
  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    s1_d  = '0;
    c1    = classify(x1);
    c2    = classify(x2);
    a_sig = {1'b1, x1[MAN_W-1:0]};
    b_sig = {1'b1, x2[MAN_W-1:0]};
    s1_d.sign = x1[EXP_W+MAN_W] ^ x2[EXP_W+MAN_W];
    s1_d.exp  = {2'b00, x1[MAN_W +: EXP_W]} + {2'b00, x2[MAN_W +: EXP_W]} - BIAS_E;
    if (c1 == NAN || c2 == NAN || (c1 == INF && c2 == ZERO) || (c1 == ZERO && c2 == INF))
      s1_d.cls = NAN;
    else if (c1 == INF || c2 == INF)
      s1_d.cls = INF;
    else if (c1 == ZERO || c2 == ZERO)
      s1_d.cls = ZERO;
    else
      s1_d.cls = NORM;
    s1_d.pp_hi    = a_sig * b_sig[SIG_W-1:LO_W];
    s1_d.pp_lo    = a_sig * b_sig[LO_W-1:0];
    s1_d.rnd_mode = rnd_mode;
    s1_d.tag      = in_tag;
  end

  always_comb begin
    s2_d = '0;
    prod = {s1_q.pp_hi, LO_W'(0)} + PROD_W'(s1_q.pp_lo);
    norm = prod[PROD_W-1] ? prod : prod << 1;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp + (EXP_W+2)'(prod[PROD_W-1]);
    s2_d.cls      = s1_q.cls;
    s2_d.sig      = norm[PROD_W-1 -: SIG_W];
    s2_d.guard    = norm[PROD_W-1-SIG_W];
    s2_d.round    = norm[PROD_W-2-SIG_W];
    s2_d.sticky   = |norm[PROD_W-3-SIG_W:0];
    s2_d.rnd_mode = s1_q.rnd_mode;
    s2_d.tag      = s1_q.tag;
  end

  fmul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sig      (s2_q.sig),
    .guard    (s2_q.guard),
    .round    (s2_q.round),
    .sticky   (s2_q.sticky),
    .rnd_mode (s2_q.rnd_mode),
    .exp_in   (s2_q.exp),
    .man      (man_r),
    .exp_out  (exp_r)
  );

  always_comb begin
    y_d     = '0;
    flags_d = 3'b000;
    case (s2_q.cls)
      NAN: begin
        y_d     = {1'b0, EXP_ONES, 1'b1, (MAN_W-1)'(0)};
        flags_d = 3'b100;
      end
      INF:  y_d = {s2_q.sign, EXP_ONES, MAN_W'(0)};
      ZERO: y_d = {s2_q.sign, (EXP_W+MAN_W)'(0)};
      default: begin
        if (!exp_r[EXP_W+1] && (exp_r[EXP_W] || exp_r[EXP_W-1:0] == EXP_ONES)) begin
          y_d     = {s2_q.sign, EXP_ONES, MAN_W'(0)};
          flags_d = 3'b010;
        end else if (exp_r[EXP_W+1] || exp_r == '0) begin
          y_d     = {s2_q.sign, (EXP_W+MAN_W)'(0)};
          flags_d = 3'b001;
        end else begin
          y_d = {s2_q.sign, exp_r[EXP_W-1:0], man_r};
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      y       <= '0;
      out_tag <= '0;
      flags   <= 3'b000;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        y       <= y_d;
        out_tag <= s2_q.tag;
        flags   <= flags_d;
      end
    end
  end

  // NOTE: inner datapath registers carry no reset; the valid bits alone decide what they mean.
  always_ff @(posedge clk) begin
    if (en1) s1_q <= s1_d;
    if (en2) s2_q <= s2_d;
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: arithmetic reference model, in-order
// scoreboard, hold/latency checks, backpressure, reset flush and random traffic.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  logic [3:0]  in_tag, out_tag;
  logic [2:0]  flags;

  int checks = 0, failures = 0, cyc = 0, outs_seen = 0;

  typedef struct {
    logic [31:0] y;
    logic [2:0]  flags;
    logic [3:0]  tag;
    bit          has_lit;
    logic [31:0] lit_y;
    logic [2:0]  lit_flags;
    bit          lat_chk;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  bit          cur_has_lit = 0, cur_lat_chk = 0;
  logic [31:0] cur_lit_y = '0;
  logic [2:0]  cur_lit_flags = '0;
  bit          held_valid = 0;
  logic [38:0] held;
  logic [34:0] m;
  bit          done = 0;

  fmul_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .rnd_mode  (rnd_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Exact product rounded with plain integer arithmetic; returns {y, flags}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic rm);
    logic s;
    int ea, eb, ex, sh;
    longint unsigned p, q, rem, half;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return {32'h7FC00000, 3'b100};
    if (a_inf || b_inf)   return {s, 8'hFF, 23'h0, 3'b000};
    if (a_zero || b_zero) return {s, 31'h0, 3'b000};
    p  = (64'(a[22:0]) | 64'h800000) * (64'(b[22:0]) | 64'h800000);
    ex = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      ex++;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (!rm && (rem > half || (rem == half && q[0]))) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 23'h0, 3'b010};
    if (ex <= 0)   return {s, 31'h0, 3'b001};
    return {s, 8'(ex), q[22:0], 3'b000};
  endfunction

  function automatic logic [31:0] rand_op();
    int         k = $urandom_range(0, 15);
    logic [7:0]  ex;
    logic [22:0] mn = 23'($urandom);
    case (k)
      0: ex = 8'h00;
      1: begin ex = 8'hFF; mn = '0; end
      2: begin ex = 8'hFF; mn[0] = 1'b1; end
      3: ex = 8'($urandom_range(1, 30));
      4: ex = 8'($urandom_range(225, 254));
      5: begin ex = 8'($urandom_range(100, 154)); mn = '1; end
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), ex, mn};
  endfunction

  // Single compare process: scoreboard push on input transfer, pop and compare on output transfer.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      sb.delete();
      held_valid = 0;
    end else begin
      if (out_valid) begin
        if (held_valid) check("hold", 64'({y, out_tag, flags}), 64'(held));
        if (out_ready) begin
          held_valid = 0;
          outs_seen++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output y=%h tag=%h required=no_output", y, out_tag);
          end else begin
            e = sb.pop_front();
            check("result", 64'({y, out_tag, flags}), 64'({e.y, e.tag, e.flags}));
            if (e.has_lit) check("literal", 64'({y, flags}), 64'({e.lit_y, e.lit_flags}));
            if (e.lat_chk) check("latency", 64'(cyc - e.cyc), 64'd3);
          end
        end else begin
          held_valid = 1;
          held       = {y, out_tag, flags};
        end
      end else begin
        held_valid = 0;
      end
      if (in_valid && in_ready) begin
        m           = model(x1, x2, rnd_mode);
        e.y         = m[34:3];
        e.flags     = m[2:0];
        e.tag       = in_tag;
        e.has_lit   = cur_has_lit;
        e.lit_y     = cur_lit_y;
        e.lit_flags = cur_lit_flags;
        e.lat_chk   = cur_lat_chk;
        e.cyc       = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic [3:0] tag);
    bit ok = 0;
    x1 = a; x2 = b; rnd_mode = rm; in_tag = tag; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    cur_has_lit = 0;
    cur_lat_chk = 0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=0 required=1");
    end
  endtask

  task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic rm, input logic [3:0] tag,
                     input logic [31:0] ly, input logic [2:0] lf);
    cur_has_lit   = 1;
    cur_lit_y     = ly;
    cur_lit_flags = lf;
    cur_lat_chk   = 1;
    drive(a, b, rm, tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, idx, seen0;
    bit took;
    logic [31:0] bp_a[5], bp_b[5];

    in_valid = 0; x1 = '0; x2 = '0; rnd_mode = 0; in_tag = '0; out_ready = 1;
    rstn = 1;
    #1 rstn = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    #2 rstn = 1;
    step(1);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    dir(32'h40000000, 32'h40400000, 1'b0, 4'd5,  32'h40C00000, 3'b000);
    dir(32'h40400000, 32'h3F800001, 1'b0, 4'd1,  32'h40400002, 3'b000);
    dir(32'h40400000, 32'h3F800001, 1'b1, 4'd2,  32'h40400001, 3'b000);
    dir(32'h7F000000, 32'hFF000000, 1'b0, 4'd3,  32'hFF800000, 3'b010);
    dir(32'h00800000, 32'h00800000, 1'b0, 4'd4,  32'h00000000, 3'b001);
    dir(32'h7F800000, 32'h00000000, 1'b0, 4'd6,  32'h7FC00000, 3'b100);
    dir(32'h80000000, 32'h3F800000, 1'b0, 4'd7,  32'h80000000, 3'b000);
    dir(32'h3F800001, 32'h3FFFFFFE, 1'b0, 4'd8,  32'h40000000, 3'b000);
    dir(32'h3F800001, 32'h3FFFFFFE, 1'b1, 4'd9,  32'h3FFFFFFF, 3'b000);
    dir(32'hFF800000, 32'h40000000, 1'b0, 4'd10, 32'hFF800000, 3'b000);
    dir(32'h7F800001, 32'h3F800000, 1'b0, 4'd11, 32'h7FC00000, 3'b100);
    dir(32'h00000001, 32'hC0000000, 1'b0, 4'd12, 32'h80000000, 3'b000);
    dir(32'h80000000, 32'hFF800000, 1'b0, 4'd13, 32'h7FC00000, 3'b100);
    step(6);

    // Backpressure: five offered back-to-back with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      bp_b[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    out_ready = 0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      x1 = bp_a[idx]; x2 = bp_b[idx]; rnd_mode = 0; in_tag = 4'(idx); in_valid = 1;
      took = 0;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        took = 1;
      end
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    in_valid = 0;
    check("bp_accepts", 64'(acc), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1;
    while (idx < 5) begin
      drive(bp_a[idx], bp_b[idx], 1'b0, 4'(idx));
      idx++;
    end
    step(6);

    // Reset with two operations in flight.
    out_ready = 0;
    drive(32'h40000000, 32'h40400000, 1'b0, 4'd14);
    drive(32'h3FC00000, 32'h3FC00000, 1'b0, 4'd15);
    step(1);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2 rstn = 0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    check("reset_flags", 64'({out_tag, flags}), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rstn = 1;
    out_ready = 1;
    seen0 = outs_seen;
    step(8);
    check("no_stale_output", 64'(outs_seen - seen0), 64'd0);
    check("in_ready_after_flush", 64'(in_ready), 64'd1);

    // Random traffic with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
          drive(rand_op(), rand_op(), 1'($urandom), 4'(i));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa width (hidden bit implicit).
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept an operand pair this cycle.
REQ-008 x1, x2  input  1+EXP_W+MAN_W  IEEE-style operands {sign, exp, man}.
REQ-009 rnd_mode  input  1  0 = round-to-nearest-even, 1 = truncate; sampled with operands.
REQ-010 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 y  output  1+EXP_W+MAN_W  product.
REQ-014 out_tag  output  TAG_W  tag of the operation in y.
REQ-015 flags  output  3  {invalid, overflow, underflow}, aligned with y.

Function
REQ-016 Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 Three register stages: S1 sign/exponent sum/special classify/partial products, S2 product sum and normalisation, S3 rounding and exception packing.
REQ-018 Latency exactly 3 cycles from input transfer to out_valid with no stall; throughput one per cycle with out_ready held high.
REQ-019 Each stage advances when its successor is empty or advancing; in_ready = !S1_valid || S1 advances (combinational, no bubble).
REQ-020 With out_ready low, S3 holds y/out_tag/flags stable; up to 3 operations buffered; none dropped or duplicated.
REQ-021 Sign = x1.sign XOR x2.sign for all results including zero, inf, overflow and underflow.
REQ-022 Exponent computed at EXP_W+2 bits signed: e1 + e2 - BIAS (BIAS = 2^(EXP_W-1)-1), +1 when the product of the 1.m significands is >= 2.
REQ-023 Significand product full width 2*(MAN_W+1); guard, round and sticky derived from the discarded bits.
REQ-024 RNE: increment when guard && (round || sticky || lsb); rounding carry-out renormalises and increments the exponent.
REQ-025 Truncate: discarded bits ignored.
REQ-026 Exponent field 0 (zero/subnormal) is treated as zero: result is a signed zero, no flags set (flush-to-zero).
REQ-027 Either operand inf (exp all ones, man 0) times nonzero: signed inf, no flags.
REQ-028 Inf times zero, or any NaN operand: canonical NaN {0, all ones, 1 followed by zeros}, invalid=1.
REQ-029 Final biased exponent >= all ones: signed inf, overflow=1.
REQ-030 Final biased exponent <= 0: signed zero, underflow=1.
REQ-031 rnd_mode and in_tag travel with their operation through every stage.

Reset
REQ-032 rstn low asynchronously clears all stage valid bits; out_valid=0, y=0, out_tag=0, flags=0.
REQ-033 in_ready=1 from the first rising clk after rstn deasserts; operations in flight at reset are discarded.

Structure
REQ-034 Shared package fpu_pkg holds the format parameters, the BIAS function, the special-value classify enum (ZERO, NORM, INF, NAN) and the per-stage struct typedefs.
REQ-035 One sub-module, fmul_round, performs guard/round/sticky rounding and renormalisation; everything else lives in fmul_pipe.

Verification
REQ-036 0x40000000 x 0x40400000, RNE, tag 5 -> y=0x40C00000, tag 5, flags 0, exactly 3 cycles after accept.
REQ-037 0x40400000 x 0x3F800001: RNE -> 0x40400002; truncate -> 0x40400001.
REQ-038 0x7F000000 x 0xFF000000 -> 0xFF800000, overflow=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1.
REQ-039 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0x80000000 x 0x3F800000 -> 0x80000000, flags 0.
REQ-040 out_ready low, 5 back-to-back inputs offered -> in_ready drops after 3 accepts; outputs emerge in order, none lost once out_ready returns high.
REQ-041 rstn pulsed low with 2 operations in flight -> out_valid=0 immediately; no stale result after release.
